uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with a compile-time frame format.
// Bytes are queued in a power-of-two FIFO and serialised LSB first by a
// five-state FSM with optional parity and one or two stop bits. The line
// output is registered, so it follows the FSM state by one clock.
module uart_tx_cfg #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int BIT_TICK = CLK_FREQ / BAUD_RATE;
   localparam int TW       = (BIT_TICK > 1) ? $clog2(BIT_TICK) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;

   localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICK - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_nonempty;
   logic          w_push;
   logic          w_pop;

   // Serialiser state
   state_t        r_state;
   state_t        w_state_next;
   logic [TW-1:0] r_tick;
   logic [TW-1:0] w_tick_next;
   logic [2:0]    r_bit_idx;
   logic [2:0]    w_bit_next;
   logic [7:0]    r_data;
   logic          r_tx;
   logic          w_tx_level;
   logic          w_tick_done;
   logic          w_parity;

   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_nonempty  = (r_count != '0);
   // A write while full is dropped even if the FSM pops in the same cycle.
   assign w_push      = in_valid && !w_full;
   assign w_tick_done = (r_tick == TICK_LAST);
   // r_data is masked on load, so the reduction covers only real data bits.
   assign w_parity    = ^r_data;

   assign in_ready    = !w_full;
   assign overflow    = in_valid && w_full;
   assign busy        = (r_state != S_IDLE) || w_nonempty;
   assign fifo_count  = r_count;
   assign tx          = r_tx;

   // FIFO data array: written on every accepted push.
   // NOTE: the storage array has no reset; it is only ever read behind the
   // count, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   // NOTE: all sequential state uses non-blocking assignment so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state register with its tick/bit counters, frame byte and line driver.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_tick    <= w_tick_next;
         r_bit_idx <= w_bit_next;
         r_tx      <= w_tx_level;
         if (w_pop) begin
            r_data <= r_mem[r_rd_ptr] & DATA_MASK;
         end
      end
   end

   // Next-state logic: each non-idle state lasts whole bit times.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick;
      w_bit_next   = r_bit_idx;
      if (r_state == S_IDLE) begin
         w_tick_next = '0;
         w_bit_next  = '0;
         if (w_nonempty) begin
            w_state_next = S_START;
         end
      end else if (!w_tick_done) begin
         w_tick_next = r_tick + TW'(1);
      end else begin
         w_tick_next = '0;
         case (r_state)
            S_START: begin
               w_state_next = S_DATA;
               w_bit_next   = '0;
            end
            S_DATA: begin
               if (r_bit_idx == DATA_LAST) begin
                  w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                  w_bit_next   = '0;
               end else begin
                  w_bit_next = r_bit_idx + 3'd1;
               end
            end
            S_PARITY: begin
               w_state_next = S_STOP;
               w_bit_next   = '0;
            end
            S_STOP: begin
               if (r_bit_idx == STOP_LAST) begin
                  w_bit_next   = '0;
                  // Back-to-back frames: go straight to START, no idle bit.
                  w_state_next = w_nonempty ? S_START : S_IDLE;
               end else begin
                  w_bit_next = r_bit_idx + 3'd1;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Output logic: line level for the current state and the FIFO pop strobe.
   always_comb begin
      w_tx_level = 1'b1;
      w_pop      = 1'b0;
      case (r_state)
         S_IDLE:   w_pop      = w_nonempty;
         S_START:  w_tx_level = 1'b0;
         S_DATA:   w_tx_level = r_data[r_bit_idx];
         S_PARITY: w_tx_level = (PARITY == 1) ? ~w_parity : w_parity;
         S_STOP:   w_pop      = w_tick_done && (r_bit_idx == STOP_LAST) && w_nonempty;
         default:  w_tx_level = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg with four instances
// (8N1 depth 16, 7E1, 8N2, 8N1 depth 4). Accepted bytes go into a
// scoreboard queue; the tx line of every instance is logged each cycle and
// each popped byte is compared cycle-by-cycle against a frame model.
module tb_uart_tx_cfg;

   localparam int NU   = 4;
   localparam int BT   = 10;
   localparam int LOGN = 4096;
   localparam int DB  [NU] = '{8, 7, 8, 8};
   localparam int PAR [NU] = '{0, 2, 0, 0};
   localparam int SB  [NU] = '{1, 1, 2, 1};

   typedef struct {
      int         unit;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] din [NU];
   logic       dv  [NU];
   logic       rdy [NU];
   logic       txl [NU];
   logic       bsy [NU];
   logic       ovf [NU];
   logic [4:0] cnt0, cnt1, cnt2;
   logic [2:0] cnt3;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic tx_log   [NU][LOGN];
   logic busy_log [NU][LOGN];
   exp_t sb_q [$];

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
      .clk(clk), .reset_n(reset_n), .in_data(din[0]), .in_valid(dv[0]),
      .in_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .fifo_count(cnt0),
      .overflow(ovf[0]));

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
      .clk(clk), .reset_n(reset_n), .in_data(din[1]), .in_valid(dv[1]),
      .in_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .fifo_count(cnt1),
      .overflow(ovf[1]));

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
      .clk(clk), .reset_n(reset_n), .in_data(din[2]), .in_valid(dv[2]),
      .in_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .fifo_count(cnt2),
      .overflow(ovf[2]));

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .reset_n(reset_n), .in_data(din[3]), .in_valid(dv[3]),
      .in_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]), .fifo_count(cnt3),
      .overflow(ovf[3]));

   // Edge counter: after rising edge k, cyc reads k at the following falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         for (int u = 0; u < NU; u++) begin
            tx_log[u][cyc]   = txl[u];
            busy_log[u][cyc] = bsy[u];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_bound", 32'(cyc >= target), 32'd1);
   endtask

   // Offer one byte from a falling edge; returns at the falling edge after
   // the accepting rising edge, with in_data scrambled to prove it is not reused.
   task automatic put(input int u, input logic [7:0] d, input bit accept);
      din[u] = d;
      dv[u]  = 1'b1;
      @(negedge clk);
      dv[u]  = 1'b0;
      din[u] = ~d;
      if (accept) sb_q.push_back('{u, d});
   endtask

   // Frame model: start, DB data bits LSB first, optional parity, SB stop bits.
   function automatic int build_levels(input int u, input logic [7:0] d, output logic lv [16]);
      logic [7:0] m;
      logic       p;
      int         n;
      for (int i = 0; i < 16; i++) lv[i] = 1'b1;
      m = d & 8'((1 << DB[u]) - 1);
      lv[0] = 1'b0;
      n = 1;
      for (int i = 0; i < DB[u]; i++) begin
         lv[n] = m[i];
         n++;
      end
      if (PAR[u] != 0) begin
         p = ^m;
         if (PAR[u] == 1) p = ~p;
         lv[n] = p;
         n++;
      end
      for (int i = 0; i < SB[u]; i++) begin
         lv[n] = 1'b1;
         n++;
      end
      return n;
   endfunction

   // Pop the next expected byte and compare every cycle of its frame,
   // whose first start-bit cycle is t0.
   task automatic check_frame(input int u, input int t0);
      exp_t e;
      logic lv [16];
      int   nb;
      int   len;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      chk("sb_unit", 32'(e.unit), 32'(u));
      nb  = build_levels(u, e.data, lv);
      len = nb * BT;
      wait_until(t0 + len + 2);
      chk($sformatf("u%0d_pre_start", u), 32'(tx_log[u][t0-1]), 32'd1);
      for (int j = 0; j < len; j++) begin
         chk($sformatf("u%0d_%02h_c%0d", u, e.data, j), 32'(tx_log[u][t0+j]), 32'(lv[j/BT]));
      end
   endtask

   // Count tx-low and busy-high cycles of unit u over [a, b].
   task automatic check_idle(input string tag, input int u, input int a, input int b);
      int lows;
      int busys;
      lows  = 0;
      busys = 0;
      wait_until(b + 1);
      for (int i = a; i <= b; i++) begin
         if (tx_log[u][i] !== 1'b1) lows++;
         if (busy_log[u][i] !== 1'b0) busys++;
      end
      chk({tag, "_tx_low_cycles"}, 32'(lows), 32'd0);
      chk({tag, "_busy_cycles"}, 32'(busys), 32'd0);
   endtask

   initial begin
      int e;
      int r;
      logic [7:0] bytes3 [6];
      logic [2:0] exp_cnt3 [6];
      bytes3   = '{8'h11, 8'h2E, 8'hF0, 8'h81, 8'h5A, 8'h00};
      exp_cnt3 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int u = 0; u < NU; u++) begin
         din[u] = 8'h00;
         dv[u]  = 1'b0;
      end

      // Reset values on every instance.
      repeat (3) @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         chk($sformatf("rst_tx_u%0d", u), 32'(txl[u]), 32'd1);
         chk($sformatf("rst_busy_u%0d", u), 32'(bsy[u]), 32'd0);
         chk($sformatf("rst_ovf_u%0d", u), 32'(ovf[u]), 32'd0);
         chk($sformatf("rst_rdy_u%0d", u), 32'(rdy[u]), 32'd1);
      end
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_cnt3", 32'(cnt3), 32'd0);

      // 8N1 0x55, offered on the first rising edge after reset release.
      reset_n = 1'b1;
      put(0, 8'h55, 1'b1);
      e = cyc;
      chk("first_write_cnt", 32'(cnt0), 32'd1);
      chk("first_write_busy", 32'(bsy[0]), 32'd1);
      check_frame(0, e + 2);
      chk("8n1_busy_in_stop", 32'(busy_log[0][e+100]), 32'd1);
      chk("8n1_busy_after", 32'(busy_log[0][e+102]), 32'd0);
      chk("8n1_tx_after", 32'(tx_log[0][e+102]), 32'd1);

      // Second byte written mid-frame must not disturb the frame in flight.
      @(negedge clk);
      put(0, 8'h3C, 1'b1);
      e = cyc;
      repeat (29) @(negedge clk);
      put(0, 8'hC3, 1'b1);
      check_frame(0, e + 2);
      check_frame(0, e + 102);
      chk("midwrite_idle_tx", 32'(tx_log[0][e+202]), 32'd1);

      // 7 data bits, even parity, 0x87.
      @(negedge clk);
      put(1, 8'h87, 1'b1);
      e = cyc;
      check_frame(1, e + 2);
      check_idle("7e1_after", 1, e + 102, e + 110);

      // Two stop bits, back-to-back 0xA3 then 0x0F.
      @(negedge clk);
      put(2, 8'hA3, 1'b1);
      e = cyc;
      put(2, 8'h0F, 1'b1);
      check_frame(2, e + 2);
      check_frame(2, e + 112);
      check_idle("8n2_after", 2, e + 222, e + 230);

      // Depth-4 FIFO, six consecutive writes with the FSM idle.
      @(negedge clk);
      e = cyc + 1;
      for (int k = 0; k < 6; k++) begin
         din[3] = bytes3[k];
         dv[3]  = 1'b1;
         #1;
         chk($sformatf("ovf_w%0d", k), 32'(ovf[3]), 32'(k == 5));
         chk($sformatf("rdy_w%0d", k), 32'(rdy[3]), 32'(k != 5));
         if (k < 5) sb_q.push_back('{3, bytes3[k]});
         @(negedge clk);
         chk($sformatf("cnt_w%0d", k), 32'(cnt3), 32'(exp_cnt3[k]));
      end
      dv[3]  = 1'b0;
      din[3] = 8'hFF;
      #1;
      chk("ovf_after", 32'(ovf[3]), 32'd0);
      for (int k = 0; k < 5; k++) begin
         check_frame(3, e + 2 + 100 * k);
      end
      check_idle("depth4_after", 3, e + 502, e + 650);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      // Reset at cycle 35 of a frame with three more bytes queued.
      @(negedge clk);
      put(0, 8'hAA, 1'b1);
      e = cyc;
      put(0, 8'hBB, 1'b1);
      put(0, 8'hCC, 1'b1);
      put(0, 8'hDD, 1'b1);
      chk("pre_reset_cnt", 32'(cnt0), 32'd3);
      wait_until(e + 2 + 35);
      chk("pre_reset_tx_low", 32'(txl[0]), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_tx", 32'(txl[0]), 32'd1);
      chk("reset_cnt", 32'(cnt0), 32'd0);
      chk("reset_busy", 32'(bsy[0]), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      r = cyc;
      check_idle("post_reset", 0, r + 1, r + 300);
      chk("post_reset_cnt", 32'(cnt0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
